// File: rtl/rot_queue_pkg.sv
// Shared defaults and entry type for the rotating multi-lane alignment queue.
package rot_queue_pkg;

  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned LANES_DEF  = 4;
  localparam int unsigned DATA_W_DEF = 32;

  typedef logic [DATA_W_DEF-1:0] entry_t;

endpackage

// File: rtl/circ_window_rotate.sv
// Combinational barrel right-rotate of the storage array by the head pointer;
// the lowest LANES entries of the result form the head-aligned window.
module circ_window_rotate #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic [DEPTH*DATA_W-1:0]   entries,
  input  logic [$clog2(DEPTH)-1:0]  shift,
  output logic [LANES*DATA_W-1:0]   window
);

  localparam int unsigned SW = $clog2(DEPTH);

  logic [DATA_W-1:0] stg [SW+1][DEPTH];

  always_comb begin
    window = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      stg[0][k] = entries[k*DATA_W +: DATA_W];
    end
    // Stage s rotates by 2**s entries when shift bit s is set; index wraps mod DEPTH.
    for (int unsigned s = 0; s < SW; s++) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stg[s+1][k] = shift[s] ? stg[s][SW'(k + (32'd1 << s))] : stg[s][k];
      end
    end
    for (int unsigned k = 0; k < LANES; k++) begin
      window[k*DATA_W +: DATA_W] = stg[SW][k];
    end
  end

endmodule

// File: rtl/rot_align_queue.sv
// Multi-lane circular queue: up to LANES pushes and pops per cycle, with a
// head-aligned output window driven purely from registered state.
module rot_align_queue
  import rot_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [$clog2(LANES+1)-1:0]   enq_cnt,
  input  logic [LANES*DATA_W-1:0]      enq_data,
  input  logic [$clog2(LANES+1)-1:0]   deq_cnt,
  output logic [LANES-1:0]             out_valid,
  output logic [LANES*DATA_W-1:0]      out_data,
  output logic [$clog2(DEPTH+1)-1:0]   free_slots,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [DEPTH*DATA_W-1:0] mem_flat;
  logic [PW-1:0]           head;
  logic [PW-1:0]           tail;
  logic [CW-1:0]           cnt;
  logic                    err_q;

  logic                    enq_ok;
  logic                    deq_ok;
  logic [CW-1:0]           free_w;
  logic [CW-1:0]           enq_add;
  logic [CW-1:0]           deq_sub;

  assign free_w  = CW'(DEPTH) - cnt;
  assign enq_ok  = CW'(enq_cnt) <= free_w;
  assign deq_ok  = CW'(deq_cnt) <= cnt;
  assign enq_add = enq_ok ? CW'(enq_cnt) : '0;
  assign deq_sub = deq_ok ? CW'(deq_cnt) : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (enq_ok) tail <= tail + PW'(enq_cnt);
      if (deq_ok) head <= head + PW'(deq_cnt);
      cnt <= cnt + enq_add - deq_sub;
      if (!enq_ok || !deq_ok) err_q <= 1'b1;
    end
  end

  // Storage has no reset; stale entries are hidden by the pointers and count.
  always_ff @(posedge clock) begin
    if (!flush && enq_ok) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (i < 32'(enq_cnt)) mem[tail + PW'(i)] <= enq_data[i*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign mem_flat[k*DATA_W +: DATA_W] = mem[k];
  end

  circ_window_rotate #(
    .DEPTH  (DEPTH),
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_rotate (
    .entries (mem_flat),
    .shift   (head),
    .window  (out_data)
  );

  always_comb begin
    out_valid = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      out_valid[k] = cnt > CW'(k);
    end
  end

  assign free_slots = free_w;
  assign count      = cnt;
  assign err        = err_q;

endmodule

// File: tb/tb_rot_align_queue.sv
// Directed and randomized checks of rot_align_queue against a queue-based model.
module tb_rot_align_queue;
  import rot_queue_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = 32;

  logic                      clock   = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      flush   = 1'b0;
  logic [2:0]                enq_cnt = '0;
  logic [LANES*DATA_W-1:0]   enq_data = '0;
  logic [2:0]                deq_cnt = '0;
  logic [LANES-1:0]          out_valid;
  logic [LANES*DATA_W-1:0]   out_data;
  logic [4:0]                free_slots;
  logic [4:0]                count;
  logic                      err;

  int     checks = 0;
  int     errors = 0;
  entry_t mq[$];
  bit     err_m = 1'b0;
  entry_t lane_d[LANES];

  rot_align_queue #(
    .DEPTH  (DEPTH),
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .enq_cnt    (enq_cnt),
    .enq_data   (enq_data),
    .deq_cnt    (deq_cnt),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .free_slots (free_slots),
    .count      (count),
    .err        (err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [LANES-1:0] v_exp;
    check({tag, ".count"}, 64'(count), 64'(mq.size()));
    check({tag, ".free"}, 64'(free_slots), 64'(DEPTH - mq.size()));
    check({tag, ".err"}, 64'(err), 64'(err_m));
    for (int k = 0; k < LANES; k++) v_exp[k] = (mq.size() > k);
    check({tag, ".valid"}, 64'(out_valid), 64'(v_exp));
    for (int k = 0; k < LANES; k++) begin
      if (k < mq.size())
        check($sformatf("%s.lane%0d", tag, k), 64'(out_data[k*DATA_W +: DATA_W]), 64'(mq[k]));
    end
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < LANES; i++) lane_d[i] = $urandom;
  endtask

  // One clock: drive inputs, advance the model, check #1 after the edge.
  task automatic step(input bit fl, input int ec, input int dc, input string tag);
    bit eo, dok;
    flush   = fl;
    enq_cnt = 3'(ec);
    deq_cnt = 3'(dc);
    for (int i = 0; i < LANES; i++) enq_data[i*DATA_W +: DATA_W] = lane_d[i];
    if (fl) begin
      mq.delete();
    end else begin
      eo  = (ec <= int'(DEPTH) - mq.size());
      dok = (dc <= mq.size());
      if (!eo || !dok) err_m = 1'b1;
      if (dok) repeat (dc) void'(mq.pop_front());
      if (eo) for (int i = 0; i < ec; i++) mq.push_back(lane_d[i]);
    end
    @(posedge clock);
    #1;
    check_state(tag);
    flush   = 1'b0;
    enq_cnt = '0;
    deq_cnt = '0;
  endtask

  // Asynchronous reset pulse between edges, checked before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    mq.delete();
    err_m = 1'b0;
    check_state(tag);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int ec, dc;
    bit fl;

    do_reset("por");

    lane_d[0] = 32'hAAAA_0001; lane_d[1] = 32'hBBBB_0002;
    lane_d[2] = 32'hCCCC_0003; lane_d[3] = 32'hDEAD_BEEF;
    step(0, 3, 0, "enq3");

    for (int i = 0; i < 3; i++) begin
      rand_lanes();
      step(0, 4, 0, "fill");
    end
    rand_lanes();
    step(0, 1, 0, "fill16");
    rand_lanes();
    step(0, 1, 2, "full_enq_deq");

    do_reset("rst2");
    for (int i = 0; i < 3; i++) begin
      rand_lanes();
      step(0, 4, 0, "pre_wrap_enq");
    end
    rand_lanes();
    step(0, 2, 0, "pre_wrap_enq2");
    for (int i = 0; i < 3; i++) step(0, 0, 4, "pre_wrap_deq");
    step(0, 0, 2, "head14");
    lane_d[0] = 32'h5757_0014; lane_d[1] = 32'h5858_0015;
    lane_d[2] = 32'h5959_0000; lane_d[3] = 32'h5A5A_0001;
    step(0, 4, 0, "wrap_window");

    rand_lanes();
    step(0, 1, 0, "count5");
    rand_lanes();
    step(0, 4, 4, "enq4_deq4");

    step(0, 0, 3, "to_count2");
    step(0, 0, 3, "over_deq");
    rand_lanes();
    step(1, 4, 4, "flush");

    do_reset("rst3");
    for (int i = 0; i < 2; i++) begin
      rand_lanes();
      step(0, 4, 0, "to9");
    end
    rand_lanes();
    step(0, 1, 0, "count9");
    do_reset("mid_reset");
    rand_lanes();
    step(0, 4, 0, "post_reset_enq");

    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) do_reset("rnd_reset");
      rand_lanes();
      fl = ($urandom_range(0, 31) == 0);
      ec = $urandom_range(0, 4);
      dc = $urandom_range(0, 4);
      if ($urandom_range(0, 9) != 0 && dc > mq.size()) dc = mq.size();
      if ($urandom_range(0, 9) != 0 && ec > int'(DEPTH) - mq.size()) ec = int'(DEPTH) - mq.size();
      step(fl, ec, dc, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
